// File: rtl/usb_tx_pck_fifo_if.sv
// Byte stream and status bundle between the USB coder / FTDI controller side
// (master) and the packet-committing transmit FIFO (slave).
interface usb_tx_pck_fifo_if #(
    parameter int ADDR_W = 9
);
    logic [7:0]      d;
    logic            d_asserted;
    logic            last_byte;
    logic            txe;
    logic [7:0]      q;
    logic            q_asserted;
    logic [ADDR_W:0] used;
    logic            pck_avail;
    logic [7:0]      drop_cnt;
    logic            ovf;

    modport master (
        output d, d_asserted, last_byte, txe,
        input  q, q_asserted, used, pck_avail, drop_cnt, ovf
    );

    modport slave (
        input  d, d_asserted, last_byte, txe,
        output q, q_asserted, used, pck_avail, drop_cnt, ovf
    );
endinterface

// File: rtl/usb_tx_pck_fifo.sv
// Packet-committing byte FIFO between the USB coder and the FTDI controller.
// Only whole packets become readable; overflowing packets are dropped whole.
module usb_tx_pck_fifo #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    usb_tx_pck_fifo_if.slave  bus
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [7:0]      mem [0:(1 << ADDR_W) - 1];
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] cmt_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic            dropping;
    logic            full;
    logic            wr_en;
    logic            rd_en;
    logic [7:0]      q_r;
    logic            q_asserted_r;
    logic [7:0]      drop_cnt_r;
    logic            ovf_r;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Full uses pre-edge pointers, so a slot freed this cycle is not reusable yet.
    assign full  = ((wr_ptr - rd_ptr) == DEPTH);
    assign wr_en = bus.d_asserted && !full && !dropping && !flush && !rst;
    assign rd_en = (cmt_ptr != rd_ptr) && !bus.txe;

    assign bus.used       = wr_ptr - rd_ptr;
    assign bus.pck_avail  = (cmt_ptr != rd_ptr);
    assign bus.q          = q_r;
    assign bus.q_asserted = q_asserted_r;
    assign bus.drop_cnt   = drop_cnt_r;
    assign bus.ovf        = ovf_r;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[ADDR_W-1:0]] <= bus.d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            cmt_ptr      <= '0;
            rd_ptr       <= '0;
            dropping     <= 1'b0;
            q_r          <= 8'd0;
            q_asserted_r <= 1'b0;
            drop_cnt_r   <= 8'd0;
            ovf_r        <= 1'b0;
        end else if (flush) begin
            wr_ptr       <= '0;
            cmt_ptr      <= '0;
            rd_ptr       <= '0;
            dropping     <= 1'b0;
            q_asserted_r <= 1'b0;
        end else begin
            if (bus.d_asserted) begin
                if (!dropping && !full) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (bus.last_byte) begin
                        cmt_ptr <= wr_ptr + 1'b1;
                    end
                end else begin
                    if (!dropping) begin
                        ovf_r <= 1'b1;
                    end
                    // End of a dropped packet: rewind its partial bytes.
                    if (bus.last_byte) begin
                        wr_ptr     <= cmt_ptr;
                        dropping   <= 1'b0;
                        drop_cnt_r <= sat_inc(drop_cnt_r);
                    end else begin
                        dropping <= 1'b1;
                    end
                end
            end

            if (rd_en) begin
                q_r          <= mem[rd_ptr[ADDR_W-1:0]];
                q_asserted_r <= 1'b1;
                rd_ptr       <= rd_ptr + 1'b1;
            end else begin
                q_asserted_r <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_usb_tx_pck_fifo.sv
// Scoreboard bench for usb_tx_pck_fifo: committed packet bytes are queued as
// they are written and compared against every q_asserted beat.
module tb_usb_tx_pck_fifo;
    localparam int ADDR_W = 9;

    logic clk;
    logic rst;
    logic flush;

    usb_tx_pck_fifo_if #(.ADDR_W(ADDR_W)) bus();

    usb_tx_pck_fifo #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    logic [7:0] exp_q [$];
    logic [7:0] pkt [$];
    int n_chk;
    int n_pass;
    int n_out;
    logic txe_prev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int len, input int base);
        pkt.delete();
        for (int i = 0; i < len; i++) pkt.push_back(8'(base + i));
    endtask

    // Drives pkt one byte per cycle; push=1 queues it as expected output.
    task automatic send(input bit last, input bit push);
        for (int i = 0; i < pkt.size(); i++) begin
            bus.d          = pkt[i];
            bus.d_asserted = 1'b1;
            bus.last_byte  = last && (i == pkt.size() - 1);
            if (push && i == pkt.size() - 1) begin
                for (int j = 0; j < pkt.size(); j++) exp_q.push_back(pkt[j]);
            end
            step();
        end
        bus.d_asserted = 1'b0;
        bus.last_byte  = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        @(negedge clk);
        chk(tag, exp_q.size(), 0);
    endtask

    always @(posedge clk) txe_prev = bus.txe;

    always @(negedge clk) begin
        if (bus.q_asserted === 1'b1) begin
            n_out++;
            chk("q_latency_txe", int'(txe_prev), 0);
            chk("sb_nonempty", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("q_data", int'(bus.q), int'(exp_q.pop_front()));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1);
    end

    initial begin
        int n0;
        int pat [9] = '{0, 1, 1, 0, 0, 1, 0, 0, 0};
        n_chk = 0; n_pass = 0; n_out = 0;
        rst = 1'b1; flush = 1'b0;
        bus.d = 8'd0; bus.d_asserted = 1'b0; bus.last_byte = 1'b0; bus.txe = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_q_asserted", int'(bus.q_asserted), 0);
        chk("rst_q", int'(bus.q), 0);
        chk("rst_used", int'(bus.used), 0);
        chk("rst_pck_avail", int'(bus.pck_avail), 0);
        chk("rst_drop_cnt", int'(bus.drop_cnt), 0);
        chk("rst_ovf", int'(bus.ovf), 0);
        step();
        rst = 1'b0;

        // 1: simple 4-byte packet, output starts the cycle after last byte
        bus.txe = 1'b0;
        pkt.delete();
        pkt.push_back(8'h11); pkt.push_back(8'h22); pkt.push_back(8'h33); pkt.push_back(8'h44);
        send(1'b1, 1'b1);
        @(negedge clk);
        chk("t1_not_early", int'(bus.q_asserted), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_burst", int'(bus.q_asserted), 1);
        end
        @(negedge clk);
        chk("t1_burst_end", int'(bus.q_asserted), 0);
        chk("t1_used", int'(bus.used), 0);
        chk("t1_sb_empty", exp_q.size(), 0);

        // 2: uncommitted bytes are held until last_byte arrives
        step();
        fill(3, 8'h01);
        send(1'b0, 1'b0);
        repeat (3) step();
        @(negedge clk);
        chk("t2_hold_qa", int'(bus.q_asserted), 0);
        chk("t2_used", int'(bus.used), 3);
        chk("t2_pck_avail", int'(bus.pck_avail), 0);
        step();
        exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
        pkt.delete();
        pkt.push_back(8'h55);
        send(1'b1, 1'b1);
        drain("t2_drain", 20);
        chk("t2_used_end", int'(bus.used), 0);

        // 3: txe backpressure mid-packet
        step();
        bus.txe = 1'b1;
        fill(6, 8'h60);
        send(1'b1, 1'b1);
        n0 = n_out;
        for (int i = 0; i < 9; i++) begin
            bus.txe = pat[i][0];
            step();
        end
        bus.txe = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("t3_pulses", n_out - n0, 6);
        chk("t3_sb_empty", exp_q.size(), 0);

        // 4: exactly-DEPTH packet accepted, following packet dropped
        step();
        fill(512, 0);
        send(1'b1, 1'b1);
        fill(3, 8'hA0);
        send(1'b1, 1'b0);
        @(negedge clk);
        chk("t4_drop_cnt", int'(bus.drop_cnt), 1);
        chk("t4_ovf", int'(bus.ovf), 1);
        chk("t4_used", int'(bus.used), 512);
        chk("t4_pck_avail", int'(bus.pck_avail), 1);
        step();
        n0 = n_out;
        bus.txe = 1'b0;
        drain("t4_drain", 600);
        chk("t4_out_count", n_out - n0, 512);
        chk("t4_used_end", int'(bus.used), 0);

        // 5: oversize packet dropped whole, next packet intact
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n0 = n_out;
        fill(600, 3);
        send(1'b1, 1'b0);
        repeat (2) step();
        @(negedge clk);
        chk("t5_drop_cnt", int'(bus.drop_cnt), 1);
        chk("t5_used", int'(bus.used), 0);
        chk("t5_ovf", int'(bus.ovf), 1);
        chk("t5_no_out", n_out - n0, 0);
        step();
        fill(2, 8'hC0);
        send(1'b1, 1'b1);
        drain("t5_drain", 20);
        chk("t5_out_count", n_out - n0, 2);

        // 6: flush mid-output keeps counters, rst clears them
        step();
        bus.txe = 1'b1;
        fill(4, 8'h40);
        send(1'b1, 1'b1);
        fill(3, 8'h50);
        send(1'b0, 1'b0);
        @(negedge clk);
        chk("t6_used_pre", int'(bus.used), 7);
        step();
        bus.txe = 1'b0;
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        exp_q.delete();
        n0 = n_out;
        @(negedge clk);
        chk("t6_flush_qa", int'(bus.q_asserted), 0);
        chk("t6_flush_used", int'(bus.used), 0);
        chk("t6_flush_pck_avail", int'(bus.pck_avail), 0);
        chk("t6_keep_drop_cnt", int'(bus.drop_cnt), 1);
        chk("t6_keep_ovf", int'(bus.ovf), 1);
        chk("t6_out_before_flush", n0 - (n_out - 2), 2);
        step();
        repeat (3) step();
        @(negedge clk);
        chk("t6_no_out_after_flush", n_out - n0, 0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_drop_cnt", int'(bus.drop_cnt), 0);
        chk("t6_rst_ovf", int'(bus.ovf), 0);
        chk("t6_rst_used", int'(bus.used), 0);
        chk("t6_rst_qa", int'(bus.q_asserted), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/usb_tx_pck_fifo.md
Name: usb_tx_pck_fifo

Overview:
- Packet-committing byte FIFO on the USB transmit path, directly downstream of the USB coder output (q / q_asserted) and upstream of the FTDI controller data input (d / d_asserted).
- Decouples coder bursts from FTDI TXE backpressure.
- Exposes only whole packets to the FTDI side, so a packet is never split by a full FTDI buffer or lost mid-stream.
- Packets that overflow are dropped whole and counted.

Parameters:
ADDR_W, 9, log2 of storage depth; DEPTH = 2^ADDR_W bytes (512).

Ports:
clk  in  1  FTDI-domain clock (FCLK_OUT)
rst  in  1  synchronous reset, active-high
flush  in  1  synchronous pointer clear, active-high
d  in  8  byte from USB coder
d_asserted  in  1  write strobe for d, one byte per cycle
last_byte  in  1  qualifies d as final byte of packet; valid only with d_asserted
txe  in  1  FTDI TXE#, active-low; 0 = FTDI can accept a byte this cycle
q  out  8  byte to FTDI controller
q_asserted  out  1  q valid strobe, one cycle per byte
used  out  ADDR_W+1  bytes stored (committed + uncommitted)
pck_avail  out  1  at least one committed byte not yet read
drop_cnt  out  8  dropped-packet counter, saturating at 255
ovf  out  1  sticky overflow flag

Behaviour:
- Clock and reset:
  - One clock; all state synchronous to clk.
  - rst is synchronous and active-high.
  - Reset values: q=0, q_asserted=0, used=0, pck_avail=0, drop_cnt=0, ovf=0, all pointers 0, drop state cleared.
- Pointers:
  - wr_ptr, cmt_ptr and rd_ptr are each ADDR_W+1 bits and wrap modulo 2^(ADDR_W+1).
  - Memory is indexed by the low ADDR_W bits.
  - used = wr_ptr - rd_ptr.
  - full = (used == DEPTH).
  - pck_avail = (cmt_ptr != rd_ptr), combinational from registered pointers.
- Write side, evaluated each cycle with d_asserted=1:
  - not full and not dropping: mem[wr_ptr]=d, wr_ptr++.
  - Accepted byte with last_byte=1: cmt_ptr = wr_ptr+1 in the same cycle, so the whole packet commits.
  - full and not dropping: byte discarded, enter DROP, ovf=1.
  - In DROP: all bytes discarded.
  - Byte with last_byte=1 while in DROP, or the byte that enters DROP when it carries last_byte=1: wr_ptr = cmt_ptr (rewind the partial packet), drop_cnt++ (saturating), exit DROP.
  - last_byte with d_asserted=0 is ignored.
- Read side:
  - Condition pck_avail=1 and txe=0 in cycle N: q <= mem[rd_ptr] and q_asserted <= 1 in cycle N+1; rd_ptr++ at edge N.
  - Otherwise q_asserted <= 0 and q holds.
  - Latency: a committed byte appears on q one cycle after txe is sampled low.
  - The earliest q_asserted for a packet is the cycle after its last_byte write.
  - Uncommitted bytes are never read.
  - txe high mid-packet pauses output; resuming causes no loss or duplication.
- Simultaneous events:
  - Read and write in the same cycle are both performed.
  - Full is evaluated on the pre-edge pointers, so a byte written in the same cycle the last slot frees is dropped (conservative).
- Packet size:
  - Packets longer than DEPTH are always dropped.
  - A packet of exactly DEPTH bytes into an empty FIFO is accepted.
- flush:
  - Sets wr_ptr=cmt_ptr=rd_ptr=0, clears DROP, forces q_asserted=0.
  - drop_cnt and ovf are retained; only rst clears them.
  - flush together with rst behaves as rst.
  - Write and read strobes in the flush cycle are ignored.
- Reset mid-packet: the partial packet is discarded and nothing is emitted.

Test Plan:
1. Reset, then write a 4-byte packet 11,22,33,44 (last on 44) with txe=0 -> q_asserted for 4 consecutive cycles starting the cycle after the 44 write, q=11,22,33,44; used returns to 0.
2. Write 3 bytes without last_byte, txe=0 -> q_asserted stays 0 and used=3; then write last byte 55 -> all 4 bytes emitted in order.
3. Committed packet of 6 bytes, txe toggles 0,1,1,0,0,1,0,0,0 -> exactly 6 q_asserted pulses, each one cycle after a txe=0 sample, with no duplicates.
4. txe=1, write a 512-byte packet, then a 3-byte packet -> first packet committed, second dropped, drop_cnt=1, ovf=1, used=512; then txe=0 -> exactly 512 bytes out.
5. Write a 600-byte packet into an empty FIFO -> drop_cnt=1, used=0, no output; a subsequent 2-byte packet passes intact.
6. Mid-output flush with 1 committed packet plus a partial packet -> q_asserted=0 the next cycle, used=0, ovf/drop_cnt unchanged; then rst -> drop_cnt=0, ovf=0.
